// File: rtl/maze_frame_painter_if.sv
// rtl/maze_frame_painter_if.sv - control, wall ROM and frame-buffer write port bundle for the maze painter
interface maze_frame_painter_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [14:0] wall_rd_addr;
  logic        wall_rd_data;
  logic [14:0] the_vga_draw_frame_write_mem_address;
  logic [23:0] the_vga_draw_frame_write_mem_data;
  logic        the_vga_draw_frame_write_a_pixel;

  // painter side: drives status, ROM address and the frame-buffer write port
  modport master (
    input  start,
    input  wall_rd_data,
    output busy,
    output done,
    output wall_rd_addr,
    output the_vga_draw_frame_write_mem_address,
    output the_vga_draw_frame_write_mem_data,
    output the_vga_draw_frame_write_a_pixel
  );

  // requester / ROM / frame-buffer side
  modport slave (
    output start,
    output wall_rd_data,
    input  busy,
    input  done,
    input  wall_rd_addr,
    input  the_vga_draw_frame_write_mem_address,
    input  the_vga_draw_frame_write_mem_data,
    input  the_vga_draw_frame_write_a_pixel
  );
endinterface

// File: rtl/maze_frame_painter.sv
// rtl/maze_frame_painter.sv - paints the maze frame buffer from a wall bitmap ROM, four cycles per word
module maze_frame_painter #(
  parameter int          MEM_SIZE          = 19200,
  parameter int          COL_HEIGHT        = 120,
  parameter int          PLAYER_START_ADDR = 7260,
  parameter int          GOAL_ADDR         = 14395,
  parameter logic [23:0] WALL_COLOR        = 24'h0000FF,
  parameter logic [23:0] FLOOR_COLOR       = 24'h000000,
  parameter logic [23:0] PLAYER_COLOR      = 24'hFF0000,
  parameter logic [23:0] GOAL_COLOR        = 24'h00FF00
) (
  input  logic                 clk,
  input  logic                 rst,
  maze_frame_painter_if.master bus
);

  // The frame must be whole columns and fit the 15-bit address space.
  if ((MEM_SIZE % COL_HEIGHT) != 0 || MEM_SIZE < 1 || MEM_SIZE > 32768) begin : g_bad_size
    $error("maze_frame_painter: MEM_SIZE must be a multiple of COL_HEIGHT and fit in 15 bits");
  end

  localparam logic [14:0] LAST_IDX   = 15'(MEM_SIZE - 1);
  localparam logic [14:0] PLAYER_IDX = 15'(PLAYER_START_ADDR);
  localparam logic [14:0] GOAL_IDX   = 15'(GOAL_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] idx_q, idx_d;
  logic        wall_q, wall_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [23:0] wr_data_q, wr_data_d;
  logic        strobe_q, strobe_d;

  // State and every output are registered; reset abandons a paint in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wall_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wall_q    <= wall_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      strobe_q  <= strobe_d;
    end
  end

  // Next-state and next-output logic; done and strobe are single-cycle pulses.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wall_d    = wall_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    strobe_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished paint.
        if (bus.start && !done_q) begin
          idx_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        wall_d  = bus.wall_rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        wr_addr_d = idx_q;
        if (idx_q == PLAYER_IDX) begin
          wr_data_d = PLAYER_COLOR;
        end else if (idx_q == GOAL_IDX) begin
          wr_data_d = GOAL_COLOR;
        end else if (wall_q) begin
          wr_data_d = WALL_COLOR;
        end else begin
          wr_data_d = FLOOR_COLOR;
        end
        strobe_d = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d     = idx_q + 15'd1;
          rd_addr_d = idx_q + 15'd1;
          state_d   = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy                                 = busy_q;
  assign bus.done                                 = done_q;
  assign bus.wall_rd_addr                         = rd_addr_q;
  assign bus.the_vga_draw_frame_write_mem_address = wr_addr_q;
  assign bus.the_vga_draw_frame_write_mem_data    = wr_data_q;
  assign bus.the_vga_draw_frame_write_a_pixel     = strobe_q;

endmodule

// File: tb/tb_maze_frame_painter.sv
// tb/tb_maze_frame_painter.sv - self-checking bench for maze_frame_painter
module tb_maze_frame_painter;
  localparam int MS = 600;
  localparam int CH = 120;
  localparam int PS = 260;
  localparam int GA = 395;
  localparam logic [23:0] WALL   = 24'h0000FF;
  localparam logic [23:0] FLOOR  = 24'h000000;
  localparam logic [23:0] PLAYER = 24'hFF0000;
  localparam logic [23:0] GOAL   = 24'h00FF00;

  logic clk = 1'b0;
  logic rst = 1'b1;

  maze_frame_painter_if bus();

  maze_frame_painter #(
    .MEM_SIZE(MS), .COL_HEIGHT(CH), .PLAYER_START_ADDR(PS), .GOAL_ADDR(GA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // wall ROM with one cycle of read latency
  logic rom [MS];
  always @(posedge clk)
    bus.wall_rd_data <= (int'(bus.wall_rd_addr) < MS) ? rom[bus.wall_rd_addr] : 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  bit mon_en = 0;
  bit running = 0;
  int start_edge = 0;
  int exp_idx = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  bit chk_hold = 0;
  logic [14:0] h_addr;
  logic [23:0] h_data;

  typedef struct {
    int pat;
    int mid_start;
    int rst_at;
    int exp_strobes;
    int exp_done;
  } vec_t;

  function automatic logic [23:0] model_color(input int i);
    if (i == PS) return PLAYER;
    if (i == GA) return GOAL;
    return rom[i] ? WALL : FLOOR;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // cycle-level checker: word order, colour, 4-cycle spacing, hold, busy and done timing
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", {31'd0, bus.busy},
          {31'd0, running && cyc >= start_edge && cyc < start_edge + 4*MS});
      if (bus.the_vga_draw_frame_write_a_pixel) begin
        chk("strobe_expected", {31'd0, running}, 32'd1);
        chk("strobe_addr", {17'd0, bus.the_vga_draw_frame_write_mem_address}, exp_idx);
        chk("strobe_data", {8'd0, bus.the_vga_draw_frame_write_mem_data},
            {8'd0, model_color(exp_idx)});
        chk("strobe_cycle", cyc, start_edge + 3 + 4*exp_idx);
        h_addr = bus.the_vga_draw_frame_write_mem_address;
        h_data = bus.the_vga_draw_frame_write_mem_data;
        chk_hold = 1;
        exp_idx++;
        strobe_cnt++;
      end else if (chk_hold) begin
        chk("hold_addr", {17'd0, bus.the_vga_draw_frame_write_mem_address}, {17'd0, h_addr});
        chk("hold_data", {8'd0, bus.the_vga_draw_frame_write_mem_data}, {8'd0, h_data});
        chk_hold = 0;
      end
      if (bus.done) begin
        chk("done_expected", {31'd0, running}, 32'd1);
        chk("done_cycle", cyc, start_edge + 4*MS);
        chk("done_strobes", strobe_cnt, MS);
        done_cnt++;
        running = 0;
      end
    end
  end

  task automatic fill_rom(input int pat);
    for (int i = 0; i < MS; i++) begin
      case (pat)
        0: rom[i] = 1'b0;
        1: rom[i] = (i < CH);
        2: rom[i] = (i == PS || i == GA) ? 1'b1 : 1'($urandom_range(0, 1));
        5: rom[i] = 1'b1;
        default: rom[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic start_paint();
    @(posedge clk); #1;
    bus.start = 1'b1;
    start_edge = cyc + 1;
    exp_idx = 0;
    strobe_cnt = 0;
    done_cnt = 0;
    chk_hold = 0;
    running = 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int k;
    k = 0;
    while (strobe_cnt < n && k < 4*MS + 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (strobe_cnt < n) begin
      miscompares++;
      $display("FAIL wait_strobes timeout got=%0d exp=%0d", strobe_cnt, n);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 4*MS + 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL wait_done timeout got=0 exp=1");
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"},   {31'd0, bus.done}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, bus.the_vga_draw_frame_write_a_pixel}, 32'd0);
    chk({tag, "_addr"},   {17'd0, bus.the_vga_draw_frame_write_mem_address}, 32'd0);
    chk({tag, "_data"},   {8'd0, bus.the_vga_draw_frame_write_mem_data}, 32'd0);
    chk({tag, "_rd_addr"}, {17'd0, bus.wall_rd_addr}, 32'd0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{pat: 0, mid_start: -1, rst_at: -1,  exp_strobes: MS,  exp_done: 1};
    tbl[1] = '{pat: 1, mid_start: -1, rst_at: -1,  exp_strobes: MS,  exp_done: 1};
    tbl[2] = '{pat: 2, mid_start: -1, rst_at: -1,  exp_strobes: MS,  exp_done: 1};
    tbl[3] = '{pat: 3, mid_start: 50, rst_at: -1,  exp_strobes: MS,  exp_done: 1};
    tbl[4] = '{pat: 4, mid_start: -1, rst_at: 100, exp_strobes: 100, exp_done: 0};
    tbl[5] = '{pat: 5, mid_start: -1, rst_at: -1,  exp_strobes: MS,  exp_done: 1};

    bus.start = 1'b0;
    fill_rom(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    mon_en = 1;
    repeat (5) @(posedge clk);

    for (int r = 0; r < 6; r++) begin
      fill_rom(tbl[r].pat);
      start_paint();
      if (tbl[r].mid_start >= 0) begin
        wait_strobes(tbl[r].mid_start);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      if (tbl[r].rst_at >= 0) begin
        wait_strobes(tbl[r].rst_at);
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        reset_checks("abort");
        rst = 1'b0;
        running = 0;
        chk_hold = 0;
        mon_en = 1;
      end else begin
        wait_done();
      end
      repeat (12) @(posedge clk);
      #1;
      chk($sformatf("row%0d_strobes", r), strobe_cnt, tbl[r].exp_strobes);
      chk($sformatf("row%0d_done", r), done_cnt, tbl[r].exp_done);
    end

    // start raised exactly in the done cycle must be dropped
    fill_rom(3);
    start_paint();
    while (cyc < start_edge + 4*MS && done_cnt == 0) begin
      @(posedge clk); #1;
    end
    chk("done_cycle_seen", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_at_done_busy", {31'd0, bus.busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("start_at_done_strobes", strobe_cnt, MS);
    chk("start_at_done_count", done_cnt, 1);

    // next IDLE start is accepted and paints from address 0 again
    start_paint();
    chk("restart_busy", {31'd0, bus.busy}, 32'd1);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    chk("restart_strobes", strobe_cnt, MS);
    chk("restart_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
